// File: rtl/cam_sched_pkg.sv
// Shared types and field positions for the camera command scheduler.
package cam_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_DELAY     = 3'd4
  } state_t;

  localparam int CMD_W  = 17;
  localparam int RESP_W = 18;

  // command fields
  localparam int CMD_RD      = 16;
  localparam int CMD_ADDR_HI = 15;
  localparam int CMD_ADDR_LO = 8;
  localparam int CMD_DATA_HI = 7;
  localparam int CMD_DATA_LO = 0;

  // response fields
  localparam int RESP_ERR     = 17;
  localparam int RESP_TMO     = 16;
  localparam int RESP_ADDR_HI = 15;
  localparam int RESP_ADDR_LO = 8;

  // read to this address in the init table means "wait n delay units"
  localparam logic [7:0] DELAY_TAG = 8'hFF;

  function automatic logic is_delay_entry(input logic [CMD_W-1:0] e);
    return e[CMD_RD] && (e[CMD_ADDR_HI:CMD_ADDR_LO] == DELAY_TAG);
  endfunction

  function automatic logic [RESP_W-1:0] timeout_resp(input logic [7:0] addr);
    return {1'b1, 1'b1, addr, 8'h00};
  endfunction

endpackage

// File: rtl/cam_sched_timer.sv
// 32-bit counter shared by the delay and response-timeout phases.
// Priority: clear, load, increment, decrement.
module cam_sched_timer #(
  parameter int unsigned TERM = 200000
) (
  input  logic        ACLK,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        inc,
  input  logic        dec,
  output logic        zero,
  output logic        term
);

  localparam logic [31:0] TERM_M1 = 32'(TERM - 1);

  logic [31:0] cnt;

  // counter register
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt + 32'd1;
    else if (dec)  cnt <= cnt - 32'd1;
  end

  assign zero = (cnt == 32'd0);
  assign term = (cnt == TERM_M1);

endmodule

// File: rtl/cam_cmd_sched.sv
// Camera register command scheduler: arbitrates the boot init sequence and
// MMIO commands onto one SCCB/I2C engine. Optional macro CAM_SCHED_RETRY_EN
// enables up to 3 retries of a nacked/timed-out command.
//
// state       | meaning
// ------------+------------------------------------------------------
// S_IDLE      | pick next work: pending restart, init entry, MMIO cmd
// S_FETCH     | init table entry on tbl_data, classify cmd vs delay
// S_ISSUE     | eng_cmd_valid high until the engine accepts
// S_WAIT_RESP | counting up, waiting for response or timeout
// S_DELAY     | counting down a delay entry
module cam_cmd_sched
  import cam_sched_pkg::*;
#(
  parameter int unsigned INIT_LEN       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned DELAY_UNIT     = 1000,
  parameter int unsigned TBL_AW         = 8
) (
  input  logic              ACLK,
  input  logic              rst_n,
  input  logic [16:0]       rw_cmd,
  input  logic              rw_cmd_valid,
  output logic [17:0]       rw_resp,
  output logic              rw_resp_valid,
  input  logic              init_start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [16:0]       tbl_data,
  output logic [16:0]       eng_cmd,
  output logic              eng_cmd_valid,
  input  logic              eng_cmd_ready,
  input  logic [17:0]       eng_resp,
  input  logic              eng_resp_valid,
  output logic              init_done,
  output logic [7:0]        init_err_cnt,
  output logic              mmio_ovf,
  output logic              busy
);

  localparam logic [31:0]       DU32     = 32'(DELAY_UNIT);
  localparam logic [TBL_AW-1:0] LAST_IDX = TBL_AW'(INIT_LEN - 1);

  state_t state, state_nxt;

  logic              init_active, init_pending;
  logic [TBL_AW-1:0] idx;
  logic              hold_vld;
  logic [16:0]       hold_cmd;
  logic [16:0]       cmd_r;
  logic              cur_init;
  logic [7:0]        err_cnt;
  logic              done_r, ovf_r;
  logic [17:0]       rsp_r;
  logic              rsp_vld_r;

  logic              take_pending, take_hold, fetch_cmd, complete, delay_done;
  logic [17:0]       resp_val;
  logic              tmr_clr, tmr_load, tmr_inc, tmr_dec, tmr_zero, tmr_term;
  logic [31:0]       tmr_load_val;
  logic              init_adv;
`ifdef CAM_SCHED_RETRY_EN
  logic [1:0]        retry_cnt;
  logic              retry_now;
`endif

  cam_sched_timer #(.TERM(TIMEOUT_CYCLES)) u_timer (
    .ACLK     (ACLK),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .inc      (tmr_inc),
    .dec      (tmr_dec),
    .zero     (tmr_zero),
    .term     (tmr_term)
  );

  // state register
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_nxt    = state;
    take_pending = 1'b0;
    take_hold    = 1'b0;
    fetch_cmd    = 1'b0;
    complete     = 1'b0;
    delay_done   = 1'b0;
    resp_val     = '0;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_inc      = 1'b0;
    tmr_dec      = 1'b0;
`ifdef CAM_SCHED_RETRY_EN
    retry_now    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // a restart is applied first and the table address settles for a cycle
        if (init_pending) begin
          take_pending = 1'b1;
        end else if (init_active) begin
          state_nxt = S_FETCH;
        end else if (hold_vld) begin
          take_hold = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_FETCH: begin
        if (is_delay_entry(tbl_data)) begin
          tmr_load     = 1'b1;
          tmr_load_val = 32'(tbl_data[CMD_DATA_HI:CMD_DATA_LO]) * DU32;
          state_nxt    = S_DELAY;
        end else begin
          fetch_cmd = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (eng_cmd_ready) begin
          tmr_clr   = 1'b1;
          state_nxt = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        tmr_inc = 1'b1;
        if (eng_resp_valid || tmr_term) begin
          resp_val = eng_resp_valid ? eng_resp
                                    : timeout_resp(cmd_r[CMD_ADDR_HI:CMD_ADDR_LO]);
`ifdef CAM_SCHED_RETRY_EN
          if ((resp_val[RESP_ERR] || resp_val[RESP_TMO]) && (retry_cnt != 2'd3)) begin
            retry_now = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            complete  = 1'b1;
            state_nxt = S_IDLE;
          end
`else
          complete  = 1'b1;
          state_nxt = S_IDLE;
`endif
        end
      end
      S_DELAY: begin
        if (tmr_zero) begin
          delay_done = 1'b1;
          state_nxt  = S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign init_adv = delay_done || (complete && cur_init);

  // init sequencing, MMIO holding register and response routing
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      init_active  <= 1'b1;
      init_pending <= 1'b0;
      idx          <= '0;
      hold_vld     <= 1'b0;
      hold_cmd     <= '0;
      cmd_r        <= '0;
      cur_init     <= 1'b0;
      err_cnt      <= '0;
      done_r       <= 1'b0;
      ovf_r        <= 1'b0;
      rsp_r        <= '0;
      rsp_vld_r    <= 1'b0;
`ifdef CAM_SCHED_RETRY_EN
      retry_cnt    <= '0;
`endif
    end else begin
      rsp_vld_r <= 1'b0;

      if (take_pending) init_pending <= 1'b0;
      if (init_start)   init_pending <= 1'b1;

      if (take_pending) begin
        idx         <= '0;
        init_active <= 1'b1;
        done_r      <= 1'b0;
        err_cnt     <= '0;
      end

      // a slot freed this cycle can be refilled in the same cycle
      if (rw_cmd_valid) begin
        if (!hold_vld || take_hold) begin
          hold_cmd <= rw_cmd;
          hold_vld <= 1'b1;
        end else begin
          ovf_r <= 1'b1;
        end
      end else if (take_hold) begin
        hold_vld <= 1'b0;
      end

      if (take_hold) begin
        cmd_r    <= hold_cmd;
        cur_init <= 1'b0;
      end
      if (fetch_cmd) begin
        cmd_r    <= tbl_data;
        cur_init <= 1'b1;
      end

`ifdef CAM_SCHED_RETRY_EN
      if (take_hold || fetch_cmd) retry_cnt <= '0;
      else if (retry_now)         retry_cnt <= retry_cnt + 2'd1;
`endif

      if (complete) begin
        if (cur_init) begin
          if (resp_val[RESP_ERR] && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end else begin
          rsp_r     <= resp_val;
          rsp_vld_r <= 1'b1;
        end
      end

      if (init_adv) begin
        if (idx == LAST_IDX) begin
          init_active <= 1'b0;
          done_r      <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign tbl_addr      = idx;
  assign eng_cmd       = cmd_r;
  assign eng_cmd_valid = (state == S_ISSUE);
  assign rw_resp       = rsp_r;
  assign rw_resp_valid = rsp_vld_r;
  assign init_done     = done_r;
  assign init_err_cnt  = err_cnt;
  assign mmio_ovf      = ovf_r;
  assign busy          = (state != S_IDLE) || hold_vld;

endmodule

// File: tb/tb_cam_cmd_sched.sv
// Directed bench for cam_cmd_sched with a small init table and engine model.
module tb_cam_cmd_sched;

  localparam int INIT_LEN = 3;
  localparam int TMO      = 40;
  localparam int DU       = 10;

  logic        ACLK, rst_n;
  logic [16:0] rw_cmd;
  logic        rw_cmd_valid;
  logic [17:0] rw_resp;
  logic        rw_resp_valid;
  logic        init_start;
  logic [7:0]  tbl_addr;
  logic [16:0] tbl_data;
  logic [16:0] eng_cmd;
  logic        eng_cmd_valid, eng_cmd_ready;
  logic [17:0] eng_resp;
  logic        eng_resp_valid;
  logic        init_done;
  logic [7:0]  init_err_cnt;
  logic        mmio_ovf, busy;

  cam_cmd_sched #(.INIT_LEN(INIT_LEN), .TIMEOUT_CYCLES(TMO), .DELAY_UNIT(DU), .TBL_AW(8)) dut (
    .ACLK(ACLK), .rst_n(rst_n), .rw_cmd(rw_cmd), .rw_cmd_valid(rw_cmd_valid),
    .rw_resp(rw_resp), .rw_resp_valid(rw_resp_valid), .init_start(init_start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .eng_cmd(eng_cmd),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
    .eng_resp(eng_resp), .eng_resp_valid(eng_resp_valid), .init_done(init_done),
    .init_err_cnt(init_err_cnt), .mmio_ovf(mmio_ovf), .busy(busy)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int cyc = 0;
  initial forever @(posedge ACLK) cyc++;

  // synchronous init table: data follows address by one cycle
  logic [16:0] tbl_mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) tbl_mem[i] = '0;
    tbl_mem[0] = 17'h0_1280;
    tbl_mem[1] = 17'h1_FF02;
    tbl_mem[2] = 17'h0_1101;
    tbl_data   = '0;
  end
  always @(posedge ACLK) tbl_data <= tbl_mem[tbl_addr];

  // engine model: responds 5 cycles after accept unless silent
  int          n_txn = 0;
  logic [16:0] txn_cmd [0:63];
  int          txn_cyc [0:63];
  bit          eng_silent = 0;
  int          nack_left  = 0;
  initial begin
    logic [16:0] c;
    logic        nk;
    eng_resp       = '0;
    eng_resp_valid = 1'b0;
    @(negedge ACLK);
    forever begin
      if (rst_n && eng_cmd_valid && eng_cmd_ready) begin
        c = eng_cmd;
        if (n_txn < 64) begin
          txn_cmd[n_txn] = c;
          txn_cyc[n_txn] = cyc;
        end
        n_txn++;
        if (eng_silent) begin
          @(negedge ACLK);
        end else begin
          nk = 1'b0;
          if (nack_left > 0 && c[15:8] == 8'h12) begin
            nk = 1'b1;
            nack_left--;
          end
          repeat (5) @(negedge ACLK);
          eng_resp       = {nk, 1'b0, c[15:8], c[16] ? 8'h76 : 8'h00};
          eng_resp_valid = 1'b1;
          @(negedge ACLK);
          eng_resp_valid = 1'b0;
        end
      end else begin
        @(negedge ACLK);
      end
    end
  end

  // rw_resp monitor
  int          n_rsp = 0;
  logic [17:0] rsp_log [0:63];
  int          rsp_cyc [0:63];
  initial forever begin
    @(negedge ACLK);
    if (rw_resp_valid) begin
      if (n_rsp < 64) begin
        rsp_log[n_rsp] = rw_resp;
        rsp_cyc[n_rsp] = cyc;
      end
      n_rsp++;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_cmd(input logic [16:0] c);
    rw_cmd       = c;
    rw_cmd_valid = 1'b1;
    @(negedge ACLK);
    rw_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      if (n_rsp >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      if (init_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int base_rsp, base_txn, cnt12, hs_cyc;

    rst_n         = 1'b0;
    rw_cmd        = '0;
    rw_cmd_valid  = 1'b0;
    init_start    = 1'b0;
    eng_cmd_ready = 1'b1;
    repeat (3) @(negedge ACLK);

    check("rst_eng_cmd_valid", eng_cmd_valid, 0);
    check("rst_eng_cmd", eng_cmd, 0);
    check("rst_rw_resp_valid", rw_resp_valid, 0);
    check("rst_rw_resp", rw_resp, 0);
    check("rst_init_done", init_done, 0);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_init_err_cnt", init_err_cnt, 0);
    check("rst_mmio_ovf", mmio_ovf, 0);
    check("rst_busy", busy, 0);

    // boot init pass, with an MMIO command posted while it runs
    rst_n = 1'b1;
    repeat (3) @(negedge ACLK);
    pulse_cmd(17'h0_2055);
    check("init_busy", busy, 1);
    wait_done(500, ok);
    check("init_done_reached", ok, 1);
    check("init_txn_count", n_txn, 2);
    check("init_txn0", txn_cmd[0], 17'h0_1280);
    check("init_txn1", txn_cmd[1], 17'h0_1101);
    check("init_gap_lo", (txn_cyc[1] - txn_cyc[0]) >= 2 * DU, 1);
    check("init_gap_hi", (txn_cyc[1] - txn_cyc[0]) <= 2 * DU + 15, 1);
    check("init_no_rw_resp", n_rsp, 0);
    check("init_err_cnt", init_err_cnt, 0);

    wait_rsp(1, 100, ok);
    check("held_rsp_arrived", ok, 1);
    check("held_txn_order", txn_cmd[2], 17'h0_2055);
    check("held_rsp", rsp_log[0], 18'h0_2000);
    repeat (5) @(negedge ACLK);

    // MMIO read
    base_rsp = n_rsp;
    pulse_cmd(17'h1_0A00);
    wait_rsp(base_rsp + 1, 100, ok);
    check("read_rsp_arrived", ok, 1);
    check("read_rsp", rsp_log[base_rsp], 18'h0_0A76);
    repeat (10) @(negedge ACLK);
    check("read_one_pulse", n_rsp, base_rsp + 1);

    // overflow: A in flight, B held, C dropped
    base_rsp = n_rsp;
    base_txn = n_txn;
    pulse_cmd(17'h0_3001);
    repeat (2) @(negedge ACLK);
    pulse_cmd(17'h0_3102);
    pulse_cmd(17'h0_3203);
    @(negedge ACLK);
    check("ovf_flag", mmio_ovf, 1);
    wait_rsp(base_rsp + 2, 100, ok);
    check("ovf_rsps_arrived", ok, 1);
    check("ovf_rsp_a", rsp_log[base_rsp], 18'h0_3000);
    check("ovf_rsp_b", rsp_log[base_rsp + 1], 18'h0_3100);
    repeat (15) @(negedge ACLK);
    check("ovf_rsp_count", n_rsp, base_rsp + 2);
    check("ovf_txn_count", n_txn, base_txn + 2);
    check("ovf_last_txn", txn_cmd[base_txn + 1], 17'h0_3102);
    check("ovf_sticky", mmio_ovf, 1);

    // timeout on a silent engine, then recovery
    eng_silent = 1;
    base_rsp   = n_rsp;
    base_txn   = n_txn;
    pulse_cmd(17'h1_4400);
    wait_rsp(base_rsp + 1, 200, ok);
    check("tmo_rsp_arrived", ok, 1);
    check("tmo_rsp", rsp_log[base_rsp], 18'h3_4400);
    hs_cyc = txn_cyc[base_txn];
    check("tmo_latency_lo", (rsp_cyc[base_rsp] - hs_cyc) >= TMO, 1);
    check("tmo_latency_hi", (rsp_cyc[base_rsp] - hs_cyc) <= TMO + 5, 1);
    eng_silent = 0;
    repeat (2) @(negedge ACLK);
    pulse_cmd(17'h0_4511);
    wait_rsp(base_rsp + 2, 100, ok);
    check("post_tmo_arrived", ok, 1);
    check("post_tmo_rsp", rsp_log[base_rsp + 1], 18'h0_4500);
    repeat (5) @(negedge ACLK);

    // re-run init with the first entry nacked twice
    nack_left  = 2;
    base_rsp   = n_rsp;
    base_txn   = n_txn;
    init_start = 1'b1;
    @(negedge ACLK);
    init_start = 1'b0;
    repeat (2) @(negedge ACLK);
    check("restart_done_clr", init_done, 0);
    wait_done(500, ok);
    check("restart_done_reached", ok, 1);
    cnt12 = 0;
    for (int i = base_txn; i < n_txn && i < 64; i++)
      if (txn_cmd[i] == 17'h0_1280) cnt12++;
`ifdef CAM_SCHED_RETRY_EN
    check("retry_txn_count", cnt12, 3);
    check("retry_err_cnt", init_err_cnt, 0);
`else
    check("noretry_txn_count", cnt12, 1);
    check("noretry_err_cnt", init_err_cnt, 1);
`endif
    check("restart_no_rw_resp", n_rsp, base_rsp);
    nack_left = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
